// File: rtl/uart_flash_dumper.sv
// UART-driven flash readback: "$dump$" + 3-byte address + 3-byte length, streamed back in chunks.
// Optional checksum byte before the trailer when DUMP_CHECKSUM_EN is defined.
module uart_flash_dumper #(
  parameter logic [47:0] DUMP_HEAD = 48'h24_64_75_6D_70_24,
  parameter logic [71:0] FDBK_DONE = 72'h64_75_6D_70_20_64_6F_6E_65,
  parameter int          MAX_CHUNK = 256
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_rx_valid_i,
  input  logic [7:0]  uart_rxdata_i,
  output logic        uart_tx_en_o,
  output logic [7:0]  uart_txdata_o,
  input  logic        uart_tx_busy_i,
  output logic        flash_rd_en_o,
  output logic [23:0] flash_rd_addr_o,
  output logic [8:0]  flash_rd_len_o,
  input  logic        flash_rd_busy_i,
  input  logic        flash_rd_valid_i,
  input  logic [7:0]  flash_rd_data_i,
  output logic        dump_busy_o
);

  localparam int          IW          = (MAX_CHUNK > 1) ? $clog2(MAX_CHUNK) : 1;
  localparam logic [8:0]  CHUNK_MAX   = 9'(MAX_CHUNK);
  localparam logic [23:0] CHUNK_MAX24 = 24'(MAX_CHUNK);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_LEN    = 3'd2,
    S_RDREQ  = 3'd3,
    S_RDWAIT = 3'd4,
    S_SEND   = 3'd5,
`ifdef DUMP_CHECKSUM_EN
    S_CSUM   = 3'd6,
`endif
    S_FDBK   = 3'd7
  } state_t;

`ifdef DUMP_CHECKSUM_EN
  localparam state_t S_POST = S_CSUM;
`else
  localparam state_t S_POST = S_FDBK;
`endif

  state_t      r_state;
  state_t      w_next_state;

  // Only five bytes are stored; the sixth header byte is the live rx byte.
  logic [39:0] r_shift;
  logic [1:0]  r_bcnt;
  logic [23:0] r_addr;
  logic [23:0] r_remain;
  logic [8:0]  r_chunk;
  logic [8:0]  r_wr_idx;
  logic [8:0]  r_rd_idx;
  logic [7:0]  r_mem [0:MAX_CHUNK-1];
  logic [7:0]  r_buf_q;
  logic        r_q_ok;
  logic        r_holdoff;
  logic [3:0]  r_fb_idx;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        r_tx_en;
  logic [7:0]  r_txdata;
  logic        r_rd_en;
  logic [23:0] r_rd_addr;
  logic [8:0]  r_rd_len;
  logic        r_busy;

  logic [47:0] w_rx_word;
  logic        w_head_hit;
  logic [23:0] w_len_word;
  logic [8:0]  w_chunk;
  logic        w_tx_ready;
  logic        w_last_byte;
  logic [6:0]  w_fb_pos;
  logic [7:0]  w_fb_byte;
  logic        w_rd_issue;
  logic        w_tx_issue;
  logic [7:0]  w_tx_byte;
  logic        w_store;

  assign w_rx_word   = {r_shift, uart_rxdata_i};
  assign w_head_hit  = uart_rx_valid_i && (w_rx_word == DUMP_HEAD);
  assign w_len_word  = {r_remain[15:0], uart_rxdata_i};
  assign w_chunk     = (r_remain >= CHUNK_MAX24) ? CHUNK_MAX : r_remain[8:0];
  assign w_tx_ready  = !uart_tx_busy_i && !r_holdoff;
  assign w_last_byte = (r_rd_idx == (r_chunk - 9'd1));
  assign w_fb_pos    = 7'd71 - {r_fb_idx, 3'b000};
  assign w_fb_byte   = FDBK_DONE[w_fb_pos -: 8];

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and per-cycle issue strobes.
  always_comb begin
    w_next_state = r_state;
    w_rd_issue   = 1'b0;
    w_tx_issue   = 1'b0;
    w_tx_byte    = 8'h00;
    w_store      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_head_hit) begin
          w_next_state = S_ADDR;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ADDR: begin
        if (uart_rx_valid_i && (r_bcnt == 2'd2)) begin
          w_next_state = S_LEN;
        end else begin
          w_next_state = S_ADDR;
        end
      end
      S_LEN: begin
        if (uart_rx_valid_i && (r_bcnt == 2'd2)) begin
          if (w_len_word == 24'd0) begin
            w_next_state = S_POST;
          end else begin
            w_next_state = S_RDREQ;
          end
        end else begin
          w_next_state = S_LEN;
        end
      end
      S_RDREQ: begin
        if (!flash_rd_busy_i) begin
          w_rd_issue   = 1'b1;
          w_next_state = S_RDWAIT;
        end else begin
          w_next_state = S_RDREQ;
        end
      end
      S_RDWAIT: begin
        if (flash_rd_valid_i && (r_wr_idx < r_chunk)) begin
          w_store = 1'b1;
          if ((r_wr_idx + 9'd1) == r_chunk) begin
            w_next_state = S_SEND;
          end else begin
            w_next_state = S_RDWAIT;
          end
        end else begin
          w_next_state = S_RDWAIT;
        end
      end
      S_SEND: begin
        // r_q_ok marks r_buf_q as holding the byte at r_rd_idx (one-cycle read).
        if (w_tx_ready && r_q_ok) begin
          w_tx_issue = 1'b1;
          w_tx_byte  = r_buf_q;
          if (w_last_byte) begin
            if (r_remain != {15'd0, r_chunk}) begin
              w_next_state = S_RDREQ;
            end else begin
              w_next_state = S_POST;
            end
          end else begin
            w_next_state = S_SEND;
          end
        end else begin
          w_next_state = S_SEND;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (w_tx_ready) begin
          w_tx_issue   = 1'b1;
          w_tx_byte    = r_csum;
          w_next_state = S_FDBK;
        end else begin
          w_next_state = S_CSUM;
        end
      end
`endif
      S_FDBK: begin
        if (w_tx_ready) begin
          w_tx_issue = 1'b1;
          w_tx_byte  = w_fb_byte;
          if (r_fb_idx == 4'd8) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_FDBK;
          end
        end else begin
          w_next_state = S_FDBK;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_shift   <= 40'd0;
      r_bcnt    <= 2'd0;
      r_addr    <= 24'd0;
      r_remain  <= 24'd0;
      r_chunk   <= 9'd0;
      r_wr_idx  <= 9'd0;
      r_rd_idx  <= 9'd0;
      r_q_ok    <= 1'b0;
      r_holdoff <= 1'b0;
      r_fb_idx  <= 4'd0;
`ifdef DUMP_CHECKSUM_EN
      r_csum    <= 8'd0;
`endif
      r_tx_en   <= 1'b0;
      r_txdata  <= 8'd0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= 24'd0;
      r_rd_len  <= 9'd0;
      r_busy    <= 1'b0;
    end else begin
      r_tx_en   <= w_tx_issue;
      r_holdoff <= w_tx_issue;
      r_rd_en   <= w_rd_issue;
      r_busy    <= (w_next_state != S_IDLE);
      r_q_ok    <= (r_state == S_SEND) && !w_tx_issue;
      if (w_tx_issue) begin
        r_txdata <= w_tx_byte;
      end
      case (r_state)
        S_IDLE: begin
          if (w_head_hit) begin
            r_shift <= 40'd0;
          end else if (uart_rx_valid_i) begin
            r_shift <= w_rx_word[39:0];
          end
          r_bcnt   <= 2'd0;
          r_fb_idx <= 4'd0;
`ifdef DUMP_CHECKSUM_EN
          r_csum   <= 8'd0;
`endif
        end
        S_ADDR: begin
          if (uart_rx_valid_i) begin
            r_addr <= {r_addr[15:0], uart_rxdata_i};
            r_bcnt <= (r_bcnt == 2'd2) ? 2'd0 : (r_bcnt + 2'd1);
          end
        end
        S_LEN: begin
          if (uart_rx_valid_i) begin
            r_remain <= w_len_word;
            r_bcnt   <= (r_bcnt == 2'd2) ? 2'd0 : (r_bcnt + 2'd1);
          end
        end
        S_RDREQ: begin
          if (w_rd_issue) begin
            r_rd_addr <= r_addr;
            r_rd_len  <= w_chunk;
            r_chunk   <= w_chunk;
            r_wr_idx  <= 9'd0;
            r_rd_idx  <= 9'd0;
          end
        end
        S_RDWAIT: begin
          if (w_store) begin
            r_wr_idx <= r_wr_idx + 9'd1;
          end
        end
        S_SEND: begin
          if (w_tx_issue) begin
            r_rd_idx <= r_rd_idx + 9'd1;
`ifdef DUMP_CHECKSUM_EN
            r_csum   <= r_csum + r_buf_q;
`endif
            if (w_last_byte) begin
              r_addr   <= r_addr + {15'd0, r_chunk};
              r_remain <= r_remain - {15'd0, r_chunk};
            end
          end
        end
        S_FDBK: begin
          if (w_tx_issue) begin
            r_fb_idx <= (r_fb_idx == 4'd8) ? 4'd0 : (r_fb_idx + 4'd1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Chunk buffer: write port from flash, registered read port towards TX.
  always_ff @(posedge sys_clk) begin
    if (w_store) begin
      r_mem[r_wr_idx[IW-1:0]] <= flash_rd_data_i;
    end
    r_buf_q <= r_mem[r_rd_idx[IW-1:0]];
  end

  assign uart_tx_en_o    = r_tx_en;
  assign uart_txdata_o   = r_txdata;
  assign flash_rd_en_o   = r_rd_en;
  assign flash_rd_addr_o = r_rd_addr;
  assign flash_rd_len_o  = r_rd_len;
  assign dump_busy_o     = r_busy;

endmodule

// File: tb/tb_uart_flash_dumper.sv
// Directed bench for uart_flash_dumper: queue-based model of the expected TX stream and flash requests.
module tb_uart_flash_dumper;

  localparam int MAXC = 256;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        uart_rx_valid_i;
  logic [7:0]  uart_rxdata_i;
  logic        uart_tx_en_o;
  logic [7:0]  uart_txdata_o;
  logic        uart_tx_busy_i;
  logic        flash_rd_en_o;
  logic [23:0] flash_rd_addr_o;
  logic [8:0]  flash_rd_len_o;
  logic        flash_rd_busy_i;
  logic        flash_rd_valid_i;
  logic [7:0]  flash_rd_data_i;
  logic        dump_busy_o;

  always #5 sys_clk = ~sys_clk;

  uart_flash_dumper dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .uart_rx_valid_i (uart_rx_valid_i),
    .uart_rxdata_i   (uart_rxdata_i),
    .uart_tx_en_o    (uart_tx_en_o),
    .uart_txdata_o   (uart_txdata_o),
    .uart_tx_busy_i  (uart_tx_busy_i),
    .flash_rd_en_o   (flash_rd_en_o),
    .flash_rd_addr_o (flash_rd_addr_o),
    .flash_rd_len_o  (flash_rd_len_o),
    .flash_rd_busy_i (flash_rd_busy_i),
    .flash_rd_valid_i(flash_rd_valid_i),
    .flash_rd_data_i (flash_rd_data_i),
    .dump_busy_o     (dump_busy_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  exp_tx[$];
  logic [32:0] exp_req[$];
  logic [7:0]  tx_log[$];
  logic [32:0] req_log[$];
  int          last_tx_cyc = -100;
  int          rd_en_cyc   = -1;
  int          drop_cyc    = 0;

  int          tx_hold = 2;
  int          tx_cnt  = 0;
  int          fl_pend = 0;
  logic [23:0] fl_addr = 24'd0;
  bit          force_fbusy = 1'b0;
  bit          extra_en    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] flash_val(input logic [23:0] a);
    if (a >= 24'h001000 && a <= 24'h001003) return 8'hAA + 8'(8'h11 * a[7:0]);
    else return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  // Model: split the length into chunks, list the bytes the host should see.
  task automatic model_dump(input logic [23:0] addr, input logic [23:0] len);
    logic [23:0] a;
    logic [23:0] left;
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [71:0] done_s;
    int          n;
    a = addr; left = len; sum = 8'd0; done_s = 72'h64_75_6D_70_20_64_6F_6E_65;
    while (left > 24'd0) begin
      n = (left > 24'(MAXC)) ? MAXC : int'(left);
      exp_req.push_back({a, 9'(n)});
      for (int i = 0; i < n; i++) begin
        b = flash_val(a + 24'(i));
        exp_tx.push_back(b);
        sum = sum + b;
      end
      a = a + 24'(n);
      left = left - 24'(n);
    end
`ifdef DUMP_CHECKSUM_EN
    exp_tx.push_back(sum);
`endif
    for (int i = 0; i < 9; i++) exp_tx.push_back(done_s[71-8*i -: 8]);
  endtask

  always @(posedge sys_clk) cyc++;

  // Compare DUT outputs against the model, then drive the flash and UART-TX responders.
  always @(negedge sys_clk) begin
    if (uart_tx_en_o === 1'b1) begin
      tx_log.push_back(uart_txdata_o);
      chk("tx_while_busy", {63'd0, uart_tx_busy_i}, 64'd0);
      chk("tx_spacing_ge2", {63'd0, (cyc - last_tx_cyc) >= 2}, 64'd1);
      last_tx_cyc = cyc;
      if (exp_tx.size() == 0) chk("tx_unexpected_byte", {56'd0, uart_txdata_o}, 64'hFFFF);
      else chk("tx_data", {56'd0, uart_txdata_o}, {56'd0, exp_tx.pop_front()});
    end
    if (flash_rd_en_o === 1'b1) begin
      req_log.push_back({flash_rd_addr_o, flash_rd_len_o});
      rd_en_cyc = cyc;
      chk("rd_while_busy", {63'd0, flash_rd_busy_i}, 64'd0);
      if (exp_req.size() == 0) chk("rd_unexpected", {31'd0, flash_rd_addr_o, flash_rd_len_o}, 64'hFFFF_FFFF_FFFF);
      else chk("rd_req", {31'd0, flash_rd_addr_o, flash_rd_len_o}, {31'd0, exp_req.pop_front()});
    end
    flash_rd_valid_i = 1'b0;
    if (sys_rst === 1'b1) fl_pend = 0;
    else if (fl_pend > 0) begin
      flash_rd_valid_i = 1'b1;
      flash_rd_data_i  = flash_val(fl_addr);
      fl_addr = fl_addr + 24'd1;
      fl_pend--;
    end
    if (flash_rd_en_o === 1'b1) begin
      fl_addr = flash_rd_addr_o;
      fl_pend = int'(flash_rd_len_o) + (extra_en ? 2 : 0);
    end
    flash_rd_busy_i = force_fbusy || (fl_pend > 0);
    if (uart_tx_en_o === 1'b1 && tx_hold > 0) tx_cnt = tx_hold;
    uart_tx_busy_i = (tx_cnt > 0);
    if (tx_cnt > 0) tx_cnt--;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    uart_rx_valid_i = 1'b1;
    uart_rxdata_i   = b;
    @(negedge sys_clk);
    uart_rx_valid_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [23:0] addr, input logic [23:0] len);
    logic [47:0] hd;
    hd = 48'h24_64_75_6D_70_24;
    for (int i = 0; i < 6; i++) send_byte(hd[47-8*i -: 8]);
    send_byte(addr[23:16]); send_byte(addr[15:8]); send_byte(addr[7:0]);
    send_byte(len[23:16]);  send_byte(len[15:8]);  send_byte(len[7:0]);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_tx.size() > 0 || dump_busy_o) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk({name, "_in_time"}, {63'd0, n < budget}, 64'd1);
    repeat (6) @(negedge sys_clk);
    chk({name, "_tx_left"}, 64'(exp_tx.size()), 64'd0);
    chk({name, "_req_left"}, 64'(exp_req.size()), 64'd0);
    chk({name, "_busy_low"}, {63'd0, dump_busy_o}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_tx_en"},   {63'd0, uart_tx_en_o}, 64'd0);
    chk({name, "_txdata"},  {56'd0, uart_txdata_o}, 64'd0);
    chk({name, "_rd_en"},   {63'd0, flash_rd_en_o}, 64'd0);
    chk({name, "_rd_addr"}, {40'd0, flash_rd_addr_o}, 64'd0);
    chk({name, "_rd_len"},  {55'd0, flash_rd_len_o}, 64'd0);
    chk({name, "_busy"},    {63'd0, dump_busy_o}, 64'd0);
  endtask

  task automatic clear_logs();
    tx_log.delete();
    req_log.delete();
  endtask

  int csum_n;
  int n_wait;

  initial begin
    csum_n = 0;
`ifdef DUMP_CHECKSUM_EN
    csum_n = 1;
`endif
    sys_rst = 1'b1; uart_rx_valid_i = 1'b0; uart_rxdata_i = 8'h00;
    uart_tx_busy_i = 1'b0; flash_rd_busy_i = 1'b0; flash_rd_valid_i = 1'b0; flash_rd_data_i = 8'h00;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset");
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Basic 4-byte dump.
    tx_hold = 2; clear_logs();
    model_dump(24'h001000, 24'd4);
    send_cmd(24'h001000, 24'd4);
    wait_done("t1", 2000);
    chk("t1_req_count", 64'(req_log.size()), 64'd1);
    chk("t1_req0", {31'd0, req_log[0]}, {31'd0, 24'h001000, 9'd4});
    chk("t1_b0", {56'd0, tx_log[0]}, 64'hAA);
    chk("t1_b1", {56'd0, tx_log[1]}, 64'hBB);
    chk("t1_b2", {56'd0, tx_log[2]}, 64'hCC);
    chk("t1_b3", {56'd0, tx_log[3]}, 64'hDD);
`ifdef DUMP_CHECKSUM_EN
    chk("t1_csum", {56'd0, tx_log[4]}, 64'h0E);
`endif
    chk("t1_fb_first", {56'd0, tx_log[4+csum_n]}, 64'h64);
    chk("t1_fb_last", {56'd0, tx_log[12+csum_n]}, 64'h65);

    // 300 bytes across the 24-bit wrap, with an overlapping "$$dump$" header.
    tx_hold = 1; clear_logs();
    model_dump(24'hFFFF80, 24'd300);
    send_byte(8'h24);
    send_cmd(24'hFFFF80, 24'd300);
    wait_done("t2", 8000);
    chk("t2_req_count", 64'(req_log.size()), 64'd2);
    chk("t2_req0", {31'd0, req_log[0]}, {31'd0, 24'hFFFF80, 9'd256});
    chk("t2_req1", {31'd0, req_log[1]}, {31'd0, 24'h000080, 9'd44});
    chk("t2_tx_count", 64'(tx_log.size()), 64'(309 + csum_n));

    // Zero length.
    tx_hold = 2; clear_logs();
    model_dump(24'h123456, 24'd0);
    send_cmd(24'h123456, 24'd0);
    wait_done("t3", 2000);
    chk("t3_req_count", 64'(req_log.size()), 64'd0);
    chk("t3_tx_count", 64'(tx_log.size()), 64'(9 + csum_n));
    chk("t3_first", {56'd0, tx_log[0]}, (csum_n == 1) ? 64'h00 : 64'h64);

    // Slow transmitter: busy for 50 cycles after each byte.
    tx_hold = 50; clear_logs();
    model_dump(24'h000200, 24'd4);
    send_cmd(24'h000200, 24'd4);
    wait_done("t4", 4000);
    chk("t4_tx_count", 64'(tx_log.size()), 64'(13 + csum_n));

    // Flash busy for 20 cycles, extra flash strobes and a garbage rx byte during SEND.
    tx_hold = 2; clear_logs();
    force_fbusy = 1'b1; flash_rd_busy_i = 1'b1; extra_en = 1'b1; rd_en_cyc = -1;
    model_dump(24'h000300, 24'd8);
    send_cmd(24'h000300, 24'd8);
    repeat (20) @(negedge sys_clk);
    chk("t5_no_rd_while_busy", 64'(req_log.size()), 64'd0);
    @(posedge sys_clk);
    #1;
    force_fbusy = 1'b0; flash_rd_busy_i = 1'b0; drop_cyc = cyc;
    n_wait = 0;
    while (tx_log.size() < 1 && n_wait < 500) begin @(negedge sys_clk); n_wait++; end
    chk("t5_send_started", {63'd0, n_wait < 500}, 64'd1);
    send_byte(8'h5A);
    wait_done("t5", 2000);
    chk("t5_rd_latency", 64'(rd_en_cyc - drop_cyc), 64'd1);
    extra_en = 1'b0;

    // Reset in the middle of SEND, then a fresh dump.
    tx_hold = 3; clear_logs();
    model_dump(24'h000400, 24'd16);
    send_cmd(24'h000400, 24'd16);
    n_wait = 0;
    while (tx_log.size() < 3 && n_wait < 1000) begin @(negedge sys_clk); n_wait++; end
    chk("t6_send_started", {63'd0, n_wait < 1000}, 64'd1);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_reset_outputs("t6_midreset");
    sys_rst = 1'b0;
    exp_tx.delete(); exp_req.delete();
    repeat (20) @(negedge sys_clk);
    chk("t6_quiet_after_reset", {63'd0, dump_busy_o}, 64'd0);
    tx_hold = 2; clear_logs();
    model_dump(24'h001000, 24'd4);
    send_cmd(24'h001000, 24'd4);
    wait_done("t6", 2000);
    chk("t6_b0", {56'd0, tx_log[0]}, 64'hAA);
    chk("t6_b3", {56'd0, tx_log[3]}, 64'hDD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
